// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the 8-phase RISC core.
//   - opcode_e      : instruction opcodes as held in the IR opcode field
//   - PH_*          : phase numbers within one instruction cycle
//   - is_alu_op()   : true for opcodes that read an operand and load ACC
// No ports; imported by the sequencer, its phase tracker and datapath blocks.
package risc_pkg;

    localparam int PHASES = 8;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    // Phase numbers; fetch is high during PH_IR_HI..PH_OPND,
    // con_alu marks PH_OPER_RD.
    localparam int PH_IR_HI     = 0;
    localparam int PH_IR_LO     = 1;
    localparam int PH_IDLE      = 2;
    localparam int PH_OPND      = 3;
    localparam int PH_HALT_CHK  = 4;
    localparam int PH_OPER_RD   = 5;
    localparam int PH_EXEC      = 6;
    localparam int PH_WRAP      = 7;

    localparam int PH_LAST_FETCH = PH_OPND;
    localparam int PH_CON_ALU    = PH_OPER_RD;

    function automatic logic is_alu_op(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/phase_tracker.sv
// phase_tracker: locks onto the fetch/con_alu strobe pattern and reports the
// current phase of the instruction cycle.
//   clk, rst      : clock, asynchronous active-low reset
//   fetch         : phase strobe, 4 clocks high then 4 low
//   con_alu       : phase strobe, high on the 2nd low clock of fetch
//   p             : current phase (valid while synced)
//   synced        : tracker locked to the strobe pattern
//   sync_err      : one-clock pulse after an edge that broke the pattern
module phase_tracker
    import risc_pkg::*;
#(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch,
    input  logic          con_alu,
    output logic [PW-1:0] p,
    output logic          synced,
    output logic          sync_err
);

    logic          fetch_q;
    logic          rising;
    logic          mismatch;
    logic [PW-1:0] pn;
    logic [PW-1:0] p_next;
    logic          synced_next;
    logic          err_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p        <= '0;
            synced   <= 1'b0;
            sync_err <= 1'b0;
            fetch_q  <= 1'b0;
        end else begin
            p        <= p_next;
            synced   <= synced_next;
            sync_err <= err_next;
            fetch_q  <= fetch;
        end
    end

    always_comb begin
        rising      = fetch & ~fetch_q;
        pn          = p + PW'(1);
        mismatch    = (fetch != (pn <= PW'(PH_LAST_FETCH))) ||
                      (con_alu != (pn == PW'(PH_CON_ALU)));
        p_next      = p;
        synced_next = synced;
        err_next    = 1'b0;
        if (!synced) begin
            if (rising) begin
                p_next      = '0;
                synced_next = 1'b1;
            end
        end else if (!mismatch) begin
            p_next = pn;
        end else begin
            err_next = 1'b1;
            // A premature fetch rise is taken as the start of a new cycle.
            if (rising) begin
                p_next = '0;
            end else begin
                synced_next = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle sequencer for the 8-phase RISC core.
//   clk, rst          : clock, asynchronous active-low reset
//   fetch, con_alu    : phase strobes from the clock generator
//   opcode, zero      : IR opcode field and ACC==0, valid by end of phase 3
//   rd, wr            : memory read / write enables
//   load_ir_hi/lo     : IR byte loads
//   inc_pc, load_pc   : PC increment / load from IR address
//   load_acc          : ACC load from ALU
//   datactl_ena       : ACC-to-data-bus driver enable
//   halt              : sticky halt flag, cleared only by reset
//   synced, sync_err  : phase tracker status
// Strobes depend only on registered state, never directly on inputs.
module cpu_sequencer
    import risc_pkg::*;
#(
    parameter int NPH = 8,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fetch,
    input  logic           con_alu,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           rd,
    output logic           wr,
    output logic           load_ir_hi,
    output logic           load_ir_lo,
    output logic           inc_pc,
    output logic           load_pc,
    output logic           load_acc,
    output logic           datactl_ena,
    output logic           halt,
    output logic           synced,
    output logic           sync_err
);

    localparam int PW = $clog2(NPH);

    logic [PW-1:0]  p;
    logic [OPW-1:0] op_q;
    logic           zq;
    opcode_e        op;

    phase_tracker #(
        .PW(PW)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .fetch    (fetch),
        .con_alu  (con_alu),
        .p        (p),
        .synced   (synced),
        .sync_err (sync_err)
    );

    assign op = opcode_e'(op_q[2:0]);

    // Operand latch at the end of phase 3; halt decision at the end of phase 4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
            zq   <= 1'b0;
            halt <= 1'b0;
        end else begin
            if (synced && (p == PW'(PH_OPND))) begin
                op_q <= opcode;
                zq   <= zero;
            end
            if (synced && (p == PW'(PH_HALT_CHK)) && (op == OP_HLT)) begin
                halt <= 1'b1;
            end
        end
    end

    always_comb begin
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir_hi  = 1'b0;
        load_ir_lo  = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        if (synced && !halt) begin
            case (p)
                PW'(PH_IR_HI): begin
                    rd         = 1'b1;
                    load_ir_hi = 1'b1;
                end
                PW'(PH_IR_LO): begin
                    rd         = 1'b1;
                    load_ir_lo = 1'b1;
                    inc_pc     = 1'b1;
                end
                PW'(PH_OPND): begin
                    inc_pc = 1'b1;
                end
                PW'(PH_OPER_RD): begin
                    rd          = is_alu_op(op);
                    datactl_ena = (op == OP_STO);
                end
                PW'(PH_EXEC): begin
                    rd          = is_alu_op(op);
                    load_acc    = is_alu_op(op);
                    wr          = (op == OP_STO);
                    datactl_ena = (op == OP_STO);
                    load_pc     = (op == OP_JMP);
                    inc_pc      = (op == OP_SKZ) && zq;
                end
                PW'(PH_WRAP): begin
                    inc_pc      = (op == OP_SKZ) && zq;
                    datactl_ena = (op == OP_STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle sequencer for the 8-phase RISC core. It consumes the `fetch` and `con_alu` phase strobes produced by the clock generator and checks that they follow the 8-clock pattern. From the current phase plus the latched opcode and accumulator-zero flag, it drives the per-phase control strobes for IR load, PC increment and load, memory read and write, the data-bus driver and the accumulator. It sits between the clock generator and the datapath (IR, PC, ACC, ALU, RAM/ROM bus).

## Interface
- `NPH`, default 8: phases per instruction cycle. Fixed by protocol; not to be overridden.
- `OPW`, default 3: opcode width.
- `clk`  in  1  system clock. All sampling is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch`  in  1  phase strobe. High for 4 consecutive clocks, then low for 4.
- `con_alu`  in  1  phase strobe. High exactly 1 clock: the 2nd low clock of `fetch`.
- `opcode`  in  OPW  IR opcode field. Valid by the end of phase 3.
- `zero`  in  1  ACC==0. Valid by the end of phase 3.
- `rd`  out  1  memory read enable.
- `wr`  out  1  memory write enable.
- `load_ir_hi`, `load_ir_lo`  out  1 each  IR byte loads.
- `inc_pc`  out  1  PC increment.
- `load_pc`  out  1  PC load from IR address.
- `load_acc`  out  1  ACC load from ALU.
- `datactl_ena`  out  1  ACC-to-data-bus driver enable.
- `halt`  out  1  sticky halt flag.
- `synced`  out  1  phase tracker locked.
- `sync_err`  out  1  one-clock pulse on protocol violation.

## Operation
- **Opcodes:** HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- **Tracker state:** `synced` flag, 3-bit phase `p`, and `fetch_q` (the previous sample of `fetch`).
- **Rising edge:** a rising edge is sampled `fetch`=1 with `fetch_q`=0.
- **Locking:** while unsynced, a rising edge sets `p`<=0 and `synced`<=1. Otherwise `p` holds.
- **Advancing:** while synced, `pn`=(p+1) mod 8 and `p`<=`pn` on every edge.
- **Checks:** each edge checks sampled `fetch`==(`pn`<=3) and sampled `con_alu`==(`pn`==5).
- **On a mismatch:**
  - `sync_err`<=1 for one clock.
  - `synced`<=0.
  - Exception: if the mismatch edge is itself a rising edge, the tracker relocks on it. `p`<=0, `synced` stays 1, and `sync_err` still pulses.
- **Operand latch:** the edge ending phase 3 (synced) latches `op_q`<=`opcode` and `zq`<=`zero`.
- **Strobe decode:** strobes decode combinationally from registered `p`, `op_q`, `zq`, `synced` and `halt` only. There is no input-to-output combinational path. All strobes are 0 when unsynced or halted.
- **Phase 0:** `rd`, `load_ir_hi`.
- **Phase 1:** `rd`, `load_ir_lo`, `inc_pc`.
- **Phase 2:** none.
- **Phase 3:** `inc_pc`.
- **Phase 4:** none. `halt`<=1 at the edge ending phase 4 if `op_q`==HLT.
- **Phase 5:**
  - ADD/AND/XOR/LDA: `rd`.
  - STO: `datactl_ena`.
- **Phase 6:**
  - ADD/AND/XOR/LDA: `rd`, `load_acc`.
  - STO: `wr`, `datactl_ena`.
  - JMP: `load_pc`.
  - SKZ with `zq`=1: `inc_pc`.
- **Phase 7:**
  - SKZ with `zq`=1: `inc_pc`.
  - STO: `datactl_ena`.
- **Halt:** `halt` stays 1 until reset. The tracker keeps running and reporting `sync_err` while halted.
- **`wr` and `rd`** are never asserted together in the same cycle.

## Timing
- **Reset values:** `synced`=0, `p`=0, `fetch_q`=0, `op_q`=0, `zq`=0, `halt`=0, `sync_err`=0. Every strobe is 0.
- **Lock latency:** phase 0 strobes appear in the clock right after the edge that samples the first `fetch` high.
- **Strobe width:** every strobe is high for whole clocks, aligned to the phase.
- **Sync loss:** strobes drop in the clock after the mismatch edge.
- **Reset mid-cycle:** immediate; all outputs return to their reset values asynchronously. Relock requires a fresh `fetch` rising edge.

## Structure
- **Shared package `risc_pkg`:** opcode localparams and phase constants. Other datapath blocks reuse them.
- **Sub-module `phase_tracker`:** holds `fetch_q`, `p`, `synced` and `sync_err`, with outputs `p` and `synced`.
- **Sequencer top:** operand latch, halt flag and strobe decode.

## Test plan
- **Lock:** reset, then drive the clean pattern (`fetch` 4 high/4 low, `con_alu` at the 2nd low). Expect `synced`=1 one clock after the first sampled `fetch` high. Phase 0 shows `rd`=1 and `load_ir_hi`=1.
- **Opcodes:** `opcode`=ADD → phase 6 has `rd`=`load_acc`=1. STO → `datactl_ena` high in phases 5–7 and `wr` only in phase 6. JMP → `load_pc` only in phase 6.
- **SKZ:** `zero`=1 → `inc_pc` in phases 1, 3, 6, 7. `zero`=0 → phases 1 and 3 only.
- **HLT:** `halt`=1 after the edge ending phase 4. All strobes stay 0 for the next 3 cycles. `halt` is cleared only by `rst`=0.
- **Protocol errors:**
  - Extra `con_alu` pulse at phase 2 → `sync_err` pulse, `synced`=0, strobes 0. Relock on the next rising edge of `fetch`.
  - Early rising edge of `fetch` at phase 6 → `sync_err` pulse, `p`=0 and `synced` stays 1.
- **Async reset:** assert `rst` during phase 6 of a STO. `wr` and `datactl_ena` fall immediately, and all outputs hold their reset values until relock.
